// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RISC-V fetch stage: PC, credit-limited imem requests, in-order instruction FIFO
module instr_fetch_unit #(
    parameter int               width    = 32,
    parameter logic [width-1:0] RESET_PC = '0,
    parameter int               DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [width-1:0] imem_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rdata,
    input  logic             redirect,
    input  logic [width-1:0] redirect_pc,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [31:0]      id_instr,
    output logic [width-1:0] id_pc,
    output logic [width-1:0] id_pc_plus4
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [width-1:0] pc;
    logic [31:0]      fifo_instr [DEPTH];
    logic [width-1:0] fifo_pc    [DEPTH];
    logic [width-1:0] shadow_pc  [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr, sq_rd, sq_wr;
    logic [CW-1:0]    count, outstanding, drop;
    logic [31:0]      hold_instr;
    logic [width-1:0] hold_pc;

    logic [CW:0] credit_used;
    logic        req_fire, rsp_eff, rsp_drop, push, pop;

    // Credit covers both buffered and in-flight fetches, so a response always has a FIFO slot.
    assign credit_used    = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_valid = !redirect && (credit_used < (CW+1)'(DEPTH));
    assign imem_addr      = pc;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_eff  = imem_rsp_valid && (outstanding != '0);
    assign rsp_drop = rsp_eff && (redirect || (drop != '0));
    assign push     = rsp_eff && !rsp_drop;
    assign pop      = id_valid && id_ready;

    // When empty the outputs hold the last delivered entry rather than a stale slot.
    assign id_valid    = (count != '0);
    assign id_instr    = id_valid ? fifo_instr[rd_ptr] : hold_instr;
    assign id_pc       = id_valid ? fifo_pc[rd_ptr]    : hold_pc;
    assign id_pc_plus4 = id_pc + width'(4);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            sq_rd       <= '0;
            sq_wr       <= '0;
            hold_instr  <= '0;
            hold_pc     <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_eff);
            if (pop) begin
                hold_instr <= fifo_instr[rd_ptr];
                hold_pc    <= fifo_pc[rd_ptr];
            end
            if (redirect) begin
                pc     <= redirect_pc & ~width'(3);
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                sq_rd  <= '0;
                sq_wr  <= '0;
                // Everything still pending after this cycle belongs to the old path.
                drop   <= outstanding - CW'(rsp_eff);
            end else begin
                if (req_fire) begin
                    pc    <= pc + width'(4);
                    sq_wr <= sq_wr + PW'(1);
                end
                if (rsp_drop) begin
                    drop <= drop - CW'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                    sq_rd  <= sq_rd + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && req_fire) begin
            shadow_pc[sq_wr] <= pc;
        end
        if (rst_n && push) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= shadow_pc[sq_rd];
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit with a latency-programmable memory model
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    instr_fetch_unit #(.width(32), .RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
        .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t       mq[$];
    logic [63:0] sb[$];
    int cyc = 0;
    int lat = 1;
    int n_acc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    logic force_rsp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: in-order, responds lat cycles after acceptance with instr = ~addr.
    initial begin
        mreq_t m;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mq.delete();
                n_acc = 0;
            end else if (imem_req_valid && imem_req_ready) begin
                mq.push_back('{imem_addr, cyc + lat});
                n_acc++;
            end
            @(posedge clk);
            #2;
            if (force_rsp) begin
                imem_rsp_valid = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
            end else if (mq.size() > 0 && mq[0].due <= cyc) begin
                m = mq.pop_front();
                imem_rsp_valid = 1'b1;
                imem_rdata = ~m.addr;
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rdata = '0;
            end
        end
    end

    // Monitor: every decode handshake is checked against the head of the scoreboard.
    initial begin
        logic [63:0] e;
        logic [31:0] epc;
        forever begin
            @(negedge clk);
            if (rst_n && id_valid && id_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_decode: got pc %h instr %h, required none", id_pc, id_instr);
                end else begin
                    e = sb.pop_front();
                    epc = e[31:0];
                    if (id_instr !== e[63:32] || id_pc !== epc || id_pc_plus4 !== epc + 32'd4) begin
                        n_bad++;
                        $display("FAIL decode: got pc %h instr %h pc4 %h, required pc %h instr %h pc4 %h",
                                 id_pc, id_instr, id_pc_plus4, epc, e[63:32], epc + 32'd4);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp_v);
        end
    endtask

    task automatic expect_pc(input logic [31:0] p);
        sb.push_back({~p, p});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        step();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        for (int k = 0; k < max_cycles; k++) begin
            if (sb.size() == 0) break;
            step();
        end
        check(name, 32'(sb.size()), 32'd0);
        id_ready = 1'b0;
        sb.delete();
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_instr", id_instr, 32'h0);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_id_pc_plus4", id_pc_plus4, 32'h4);

        // Free run, latency 1
        for (int i = 0; i < 12; i++) expect_pc(32'(i * 4));
        step();
        rst_n = 1'b1;
        id_ready = 1'b1;
        @(negedge clk);
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_addr, 32'h0);
        check("first_id_valid", 32'(id_valid), 32'd0);
        check("first_pc_plus4", id_pc_plus4, 32'h4);
        step();
        @(negedge clk);
        check("lat_id_valid", 32'(id_valid), 32'd0);
        step();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("thruput_id_valid", 32'(id_valid), 32'd1);
            step();
        end
        wait_drain("run_drain", 2);

        // Backpressure
        do_reset();
        repeat (10) step();
        @(negedge clk);
        check("bp_id_valid", 32'(id_valid), 32'd1);
        check("bp_head_pc", id_pc, 32'h0);
        check("bp_head_instr", id_instr, 32'hFFFF_FFFF);
        check("bp_req_valid", 32'(imem_req_valid), 32'd0);
        check("bp_accepted", 32'(n_acc), 32'd4);
        for (int i = 0; i < 8; i++) expect_pc(32'(i * 4));
        step();
        id_ready = 1'b1;
        wait_drain("bp_drain", 40);

        // Redirect with two stale responses, latency 3
        lat = 3;
        for (int i = 0; i < 3; i++) expect_pc(32'h100 + 32'(i * 4));
        do_reset();
        id_ready = 1'b1;
        step();
        step();
        imem_req_ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h103;
        @(negedge clk);
        check("redir_no_req", 32'(imem_req_valid), 32'd0);
        step();
        redirect = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        check("redir_req_valid", 32'(imem_req_valid), 32'd1);
        check("redir_req_addr", imem_addr, 32'h100);
        wait_drain("redir_drain", 40);

        // Redirect colliding with a response and a decode handshake
        lat = 1;
        expect_pc(32'h0);
        expect_pc(32'h200);
        expect_pc(32'h204);
        do_reset();
        id_ready = 1'b1;
        step();
        step();
        redirect = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        @(negedge clk);
        check("coll_id_valid", 32'(id_valid), 32'd0);
        check("coll_hold_pc", id_pc, 32'h0);
        wait_drain("coll_drain", 40);

        // PC wrap at the top of the address space
        expect_pc(32'hFFFF_FFFC);
        expect_pc(32'h0);
        expect_pc(32'h4);
        do_reset();
        id_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        @(negedge clk);
        check("wrap_no_req", 32'(imem_req_valid), 32'd0);
        step();
        redirect = 1'b0;
        @(negedge clk);
        check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        step();
        @(negedge clk);
        check("wrap_addr_zero", imem_addr, 32'h0);
        wait_drain("wrap_drain", 40);

        // Reset mid-stream with a full FIFO, then a spurious response
        do_reset();
        repeat (8) step();
        @(negedge clk);
        check("full_id_valid", 32'(id_valid), 32'd1);
        check("full_req_valid", 32'(imem_req_valid), 32'd0);
        step();
        rst_n = 1'b0;
        expect_pc(32'h0);
        expect_pc(32'h4);
        step();
        rst_n = 1'b1;
        force_rsp = 1'b1;
        id_ready = 1'b1;
        @(negedge clk);
        check("mrst_id_valid", 32'(id_valid), 32'd0);
        check("mrst_req_valid", 32'(imem_req_valid), 32'd1);
        check("mrst_req_addr", imem_addr, 32'h0);
        step();
        force_rsp = 1'b0;
        @(negedge clk);
        check("spurious_ignored", 32'(id_valid), 32'd0);
        wait_drain("mrst_drain", 40);

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
